keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Front end of the vending machine: scans a 4x4 active-high matrix keypad, debounces contacts,
//  and emits one KEY_PRESS pulse per accepted key with the decoded 4-bit ITEM_CODE. Its
//  ITEM_CODE/KEY_PRESS outputs connect directly to the vending_machine inputs of the same
//  names. ENABLE is tied to CARD_IN; keys are ignored while no card is inserted.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive identical synced samples needed to accept a press or release (>=2)
//  SCAN_DWELL       4   cycles each row is driven while scanning (>=3, covers 2-FF sync latency)
//  REPEAT_CYCLES    16  held-key cycles between auto-repeat pulses (used only with KEY_REPEAT_EN)
// PORTS
//  CLK        in   1  system clock; all state updates on rising edge
//  RESET      in   1  asynchronous, active-high reset
//  ENABLE     in   1  scan enable (CARD_IN); low = idle
//  COL_SENSE  in   4  raw keypad columns, active-high, asynchronous to CLK
//  ROW_DRIVE  out  4  one-hot active-high row strobe; 4'b0000 when idle
//  ITEM_CODE  out  4  code of the last accepted key = 4*row + col; holds between presses
//  KEY_PRESS  out  1  one-cycle pulse, coincident with a new ITEM_CODE
// BEHAVIOUR
//  Reset: state=IDLE, ROW_DRIVE=0, ITEM_CODE=0, KEY_PRESS=0, row=0, all counters and sync FFs=0.
//  COL_SENSE passes through a 2-FF synchronizer; all decisions below use the synced value (col_s).
//  States:
//   IDLE:      ROW_DRIVE=0. If ENABLE=1 -> SCAN, row=0, dwell=0.
//   SCAN:      ROW_DRIVE=1<<row. On the last dwell cycle (dwell==SCAN_DWELL-1):
//              col_s==0 -> row=(row+1)%4 (3 wraps to 0); col_s multi-bit -> ghost reject, next row;
//              col_s one-hot -> latch col, go to DEBOUNCE with cnt=1 and row held.
//   DEBOUNCE:  Row held. Each cycle col_s==latched col -> cnt++; any other value -> SCAN at the next row.
//              When cnt reaches DEBOUNCE_CYCLES -> PRESSED.
//   PRESSED:   Lasts one cycle: KEY_PRESS=1, ITEM_CODE={row[1:0],col_idx[1:0]} -> WAIT_REL.
//   WAIT_REL:  Row held. Needs DEBOUNCE_CYCLES consecutive cycles with col_s==0 (any nonzero
//              sample clears the count). Then -> SCAN at the next row.
//  Latency: a clean press is seen at most 4*SCAN_DWELL + 2 (sync) + DEBOUNCE_CYCLES cycles after
//   it becomes stable. KEY_PRESS always comes one cycle after the last debounce sample.
//  Only one key is handled at a time. A second key in another row is ignored until release is accepted.
//  Codes 0-9 are digits; 10-15 are passed through unchanged, and vending_machine flags them INVALID_SEL.
//  ENABLE low in any state -> IDLE on the next edge: ROW_DRIVE=0, counters cleared, no pulse,
//   ITEM_CODE held. If a key is still held when ENABLE rises, it is scanned and accepted normally
//   (one pulse).
//  An async RESET at any point (including mid-DEBOUNCE or PRESSED) forces the reset values immediately.
//   A KEY_PRESS cut short by reset is not reissued.
//  KEY_PRESS is never high on two consecutive cycles.
// CONFIGURATION
//  KEY_REPEAT_EN defined: in WAIT_REL, a repeat counter runs while col_s==latched col. Each time it
//   reaches REPEAT_CYCLES it clears and KEY_PRESS pulses again with the same ITEM_CODE. The counter
//   clears on a release sample or on leaving WAIT_REL.
//  KEY_REPEAT_EN undefined: no repeat counter exists; exactly one pulse per press.
// TESTING  (DEBOUNCE_CYCLES=4, SCAN_DWELL=4, REPEAT_CYCLES=16)
//  1 Reset: assert RESET in DEBOUNCE with row 2 held -> ROW_DRIVE=0, ITEM_CODE=0, KEY_PRESS=0 at
//    once; no pulse after release.
//  2 Sequence: ENABLE=1; press row0/col1 for 30 cycles, release, then row0/col3 ->
//    exactly two pulses, ITEM_CODE=1 then 3.
//  3 Bounce: row2/col1 toggles every 2 cycles for 12 cycles, then stable 30 cycles ->
//    one pulse, ITEM_CODE=9.
//  4 Ghost: row1 col0+col2 held 40 cycles -> no pulse; ROW_DRIVE keeps cycling 1,2,4,8.
//  5 Enable: drop ENABLE in WAIT_REL -> ROW_DRIVE=0 next cycle, no pulse. Re-raise ENABLE with
//    key 7 held -> one pulse, ITEM_CODE=7.
//  6 Repeat: hold key 7 for 60 cycles after acceptance -> with KEY_REPEAT_EN, 1+3 pulses spaced
//    16 cycles apart; without it, exactly 1 pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one pulse per accepted key
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key stays held)
module keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DWELL      = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [3:0] COL_SENSE,
  output logic [3:0] ROW_DRIVE,
  output logic [3:0] ITEM_CODE,
  output logic       KEY_PRESS
);

  localparam int DW = $clog2(SCAN_DWELL);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // An illegal parameter set keeps the scanner parked in IDLE instead of misbehaving.
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (SCAN_DWELL >= 3) && (REPEAT_CYCLES >= 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_WAIT_REL
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      col_m;
  logic [3:0]      col_s;
  logic [1:0]      row;
  logic [DW-1:0]   dwell;
  logic [CW-1:0]   cnt;
  logic [3:0]      col_lat;
  logic [3:0]      item_code_q;
  logic            rep_fire;

  logic            dwell_last;
  logic            col_zero;
  logic            col_onehot;
  logic            col_match;
  logic            deb_done;
  logic            rel_done;

  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    case (c)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign dwell_last = (dwell == DW'(SCAN_DWELL - 1));
  assign col_zero   = (col_s == 4'b0000);
  assign col_onehot = !col_zero && ((col_s & (col_s - 4'd1)) == 4'b0000);
  assign col_match  = (col_s == col_lat);
  // The scan sample that latched the column counts as the first debounce sample.
  assign deb_done   = col_match && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rel_done   = col_zero && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      col_m <= 4'b0000;
      col_s <= 4'b0000;
    end else begin
      col_m <= COL_SENSE;
      col_s <= col_m;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; dropping ENABLE wins over everything.
  always_comb begin
    state_nxt = state;
    if (!ENABLE || !CFG_OK) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_SCAN;
        ST_SCAN:     if (dwell_last && col_onehot) state_nxt = ST_DEBOUNCE;
        ST_DEBOUNCE: begin
          if (!col_match)    state_nxt = ST_SCAN;
          else if (deb_done) state_nxt = ST_PRESSED;
        end
        ST_PRESSED:  state_nxt = ST_WAIT_REL;
        ST_WAIT_REL: if (rel_done) state_nxt = ST_SCAN;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Row pointer, dwell/debounce counters, latched column and the item code register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      row         <= 2'd0;
      dwell       <= '0;
      cnt         <= '0;
      col_lat     <= 4'b0000;
      item_code_q <= 4'd0;
    end else if (!ENABLE || !CFG_OK) begin
      row   <= 2'd0;
      dwell <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          row   <= 2'd0;
          dwell <= '0;
          cnt   <= '0;
        end
        ST_SCAN: begin
          if (dwell_last) begin
            dwell <= '0;
            if (col_onehot) begin
              col_lat <= col_s;
              cnt     <= CW'(1);
            end else begin
              // Empty row or ghosted multi-column pattern: move on.
              row <= row + 2'd1;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!col_match) begin
            row   <= row + 2'd1;
            dwell <= '0;
            cnt   <= '0;
          end else if (deb_done) begin
            item_code_q <= {row, col_index(col_lat)};
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          cnt <= '0;
        end
        ST_WAIT_REL: begin
          if (col_zero) begin
            if (rel_done) begin
              row   <= row + 2'd1;
              dwell <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            // Any contact restarts the release count.
            cnt <= '0;
          end
        end
        default: begin
          row   <= 2'd0;
          dwell <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] rep_cnt;

  assign rep_fire = ENABLE && (state == ST_WAIT_REL) && col_match &&
                    (rep_cnt == RW'(REPEAT_CYCLES - 1));

  // Auto-repeat counter: runs only while the same key is held in WAIT_REL.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rep_cnt <= '0;
    end else if (!ENABLE || (state != ST_WAIT_REL) || !col_match || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Outputs: row strobe follows the row pointer outside IDLE; pulse in PRESSED or on repeat.
  always_comb begin
    ROW_DRIVE = 4'b0000;
    KEY_PRESS = 1'b0;
    ITEM_CODE = item_code_q;
    if (state != ST_IDLE) begin
      ROW_DRIVE = 4'b0001 << row;
    end
    if ((state == ST_PRESSED) || rep_fire) begin
      KEY_PRESS = 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  col_sense;
  logic [3:0]  row_drive;
  logic [3:0]  item_code;
  logic        key_press;
  logic [15:0] keys;

  int checks;
  int errors;
  int pulses;
  int dbl;
  int cycle;
  logic prev_kp;
  logic [3:0] code_log [16];
  int         time_log [16];

  keypad_scanner #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_DWELL(4),
    .REPEAT_CYCLES(16)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .ENABLE(enable),
    .COL_SENSE(col_sense),
    .ROW_DRIVE(row_drive),
    .ITEM_CODE(item_code),
    .KEY_PRESS(key_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a held key connects its row strobe to its column.
  always_comb begin
    col_sense = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row_drive[r] && keys[4*r+c]) col_sense[c] = 1'b1;
      end
    end
  end

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (key_press === 1'b1) begin
      code_log[pulses % 16] = item_code;
      time_log[pulses % 16] = cycle;
      pulses = pulses + 1;
      if (prev_kp === 1'b1) dbl = dbl + 1;
    end
    prev_kp = key_press;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if (row_drive !== 4'b0000) begin
      errors++; $display("FAIL reset_row_drive: got %b want %b", row_drive, 4'b0000);
    end
    checks++;
    if (item_code !== 4'd0) begin
      errors++; $display("FAIL reset_item_code: got %0d want %0d", item_code, 0);
    end
    checks++;
    if (key_press !== 1'b0) begin
      errors++; $display("FAIL reset_key_press: got %b want %b", key_press, 1'b0);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if (row_drive !== 4'b0000) begin
      errors++; $display("FAIL idle_row_drive: got %b want %b", row_drive, 4'b0000);
    end
  endtask

  task automatic test_sequence;
    int base;
    base = pulses;
    enable = 1'b1;
    keys = 16'h0001 << 1;
    tick(30);
    keys = 16'h0000;
    tick(20);
    keys = 16'h0001 << 3;
    tick(30);
    keys = 16'h0000;
    tick(20);
    checks++;
    if (pulses - base !== 2) begin
      errors++; $display("FAIL seq_pulse_count: got %0d want %0d", pulses - base, 2);
    end
    checks++;
    if (code_log[base % 16] !== 4'd1) begin
      errors++; $display("FAIL seq_first_code: got %0d want %0d", code_log[base % 16], 1);
    end
    checks++;
    if (code_log[(base + 1) % 16] !== 4'd3) begin
      errors++; $display("FAIL seq_second_code: got %0d want %0d", code_log[(base + 1) % 16], 3);
    end
  endtask

  task automatic test_bounce;
    int base;
    base = pulses;
    for (int i = 0; i < 3; i++) begin
      keys = 16'h0001 << 9;
      tick(2);
      keys = 16'h0000;
      tick(2);
    end
    checks++;
    if (pulses - base !== 0) begin
      errors++; $display("FAIL bounce_no_early_pulse: got %0d want %0d", pulses - base, 0);
    end
    keys = 16'h0001 << 9;
    tick(30);
    keys = 16'h0000;
    tick(20);
    checks++;
    if (pulses - base !== 1) begin
      errors++; $display("FAIL bounce_pulse_count: got %0d want %0d", pulses - base, 1);
    end
    checks++;
    if (code_log[base % 16] !== 4'd9) begin
      errors++; $display("FAIL bounce_code: got %0d want %0d", code_log[base % 16], 9);
    end
  endtask

  task automatic test_ghost;
    int base;
    int trans;
    logic [3:0] prev;
    base = pulses;
    trans = 0;
    keys = (16'h0001 << 4) | (16'h0001 << 6);
    prev = row_drive;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (row_drive !== prev) begin
        checks++;
        if (row_drive !== {prev[2:0], prev[3]}) begin
          errors++; $display("FAIL ghost_row_order: got %b want %b", row_drive, {prev[2:0], prev[3]});
        end
        trans++;
        prev = row_drive;
      end
    end
    checks++;
    if (trans < 9) begin
      errors++; $display("FAIL ghost_row_cycling: got %0d transitions want at least %0d", trans, 9);
    end
    checks++;
    if (pulses - base !== 0) begin
      errors++; $display("FAIL ghost_no_pulse: got %0d want %0d", pulses - base, 0);
    end
    keys = 16'h0000;
    tick(10);
  endtask

  task automatic test_enable;
    int base;
    bit found;
    base = pulses;
    keys = 16'h0001 << 7;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (key_press === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL enable_first_accept: got timeout want pulse within %0d cycles", 60);
    end
    tick(3);
    enable = 1'b0;
    tick(1);
    checks++;
    if (row_drive !== 4'b0000) begin
      errors++; $display("FAIL enable_drop_row_drive: got %b want %b", row_drive, 4'b0000);
    end
    checks++;
    if (item_code !== 4'd7) begin
      errors++; $display("FAIL enable_drop_item_hold: got %0d want %0d", item_code, 7);
    end
    tick(10);
    checks++;
    if (pulses - base !== 1) begin
      errors++; $display("FAIL enable_drop_no_pulse: got %0d want %0d", pulses - base, 1);
    end
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (key_press === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL enable_reaccept: got timeout want pulse within %0d cycles", 60);
    end
    keys = 16'h0000;
    tick(20);
    checks++;
    if (pulses - base !== 2) begin
      errors++; $display("FAIL enable_pulse_count: got %0d want %0d", pulses - base, 2);
    end
    checks++;
    if (code_log[(base + 1) % 16] !== 4'd7) begin
      errors++; $display("FAIL enable_reaccept_code: got %0d want %0d", code_log[(base + 1) % 16], 7);
    end
  endtask

  task automatic test_repeat;
    int base;
    int exp_pulses;
    bit found;
`ifdef KEY_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    base = pulses;
    keys = 16'h0001 << 7;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (key_press === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL repeat_accept: got timeout want pulse within %0d cycles", 60);
    end
    tick(60);
    keys = 16'h0000;
    tick(20);
    checks++;
    if (pulses - base !== exp_pulses) begin
      errors++; $display("FAIL repeat_pulse_count: got %0d want %0d", pulses - base, exp_pulses);
    end
    checks++;
    if (code_log[(pulses - 1) % 16] !== 4'd7) begin
      errors++; $display("FAIL repeat_code: got %0d want %0d", code_log[(pulses - 1) % 16], 7);
    end
`ifdef KEY_REPEAT_EN
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (time_log[(base + k) % 16] - time_log[(base + k - 1) % 16] !== 16) begin
        errors++; $display("FAIL repeat_spacing: got %0d want %0d",
                           time_log[(base + k) % 16] - time_log[(base + k - 1) % 16], 16);
      end
    end
`endif
    checks++;
    if (dbl !== 0) begin
      errors++; $display("FAIL back_to_back_pulses: got %0d want %0d", dbl, 0);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit found;
    base = pulses;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (row_drive === 4'b0001) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_row0_seen: got timeout want row0 within %0d cycles", 40);
    end
    keys = 16'h0001 << 9;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (row_drive === 4'b0100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_row2_seen: got timeout want row2 within %0d cycles", 40);
    end
    // Five edges after row 2 starts the scanner sits in DEBOUNCE.
    tick(5);
    rst = 1'b1;
    #1;
    checks++;
    if (row_drive !== 4'b0000) begin
      errors++; $display("FAIL rstmid_row_drive: got %b want %b", row_drive, 4'b0000);
    end
    checks++;
    if (item_code !== 4'd0) begin
      errors++; $display("FAIL rstmid_item_code: got %0d want %0d", item_code, 0);
    end
    checks++;
    if (key_press !== 1'b0) begin
      errors++; $display("FAIL rstmid_key_press: got %b want %b", key_press, 1'b0);
    end
    keys = 16'h0000;
    tick(3);
    rst = 1'b0;
    tick(30);
    checks++;
    if (pulses - base !== 0) begin
      errors++; $display("FAIL rstmid_no_pulse: got %0d want %0d", pulses - base, 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    dbl = 0;
    cycle = 0;
    prev_kp = 1'b0;
    rst = 1'b1;
    enable = 1'b0;
    keys = 16'h0000;
    test_reset();
    test_sequence();
    test_bounce();
    test_ghost();
    test_enable();
    test_repeat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
